// File: rtl/led_pattern_seq.sv
// led_pattern_seq: spreads the breathing PWM bit over four LEDs by a button-selected pattern.
// Define LED_PATTERN_PINGPONG_EN to build the PINGPONG mode and its direction register.
module led_pattern_seq #(
    parameter int CLK_frequency = 100_000_000,
    parameter int DEBOUNCE_MS   = 20,
    parameter int STEP_MS       = 250
) (
    input  logic       clk_i,
    input  logic       rst,
    input  logic       pwm_i,
    input  logic       key_i,
    output logic [3:0] led_o,
    output logic [1:0] mode_o
);

    localparam int MS_CYC = CLK_frequency / 1000;
    localparam int DB_CYC = MS_CYC * DEBOUNCE_MS;
    localparam int MS_W   = (MS_CYC > 1) ? $clog2(MS_CYC) : 1;
    localparam int DB_W   = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;
    localparam int ST_W   = (STEP_MS > 1) ? $clog2(STEP_MS) : 1;

    localparam logic [1:0] MODE_ALL   = 2'd0;
    localparam logic [1:0] MODE_CHASE = 2'd1;
    localparam logic [1:0] MODE_PING  = 2'd2;
    localparam logic [1:0] MODE_OFF   = 2'd3;

    logic [1:0]      sync_q, sync_d;
    logic            key_st_q, key_st_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            press_q, press_d;
    logic [1:0]      mode_q, mode_d;
    logic [MS_W-1:0] ms_cnt_q, ms_cnt_d;
    logic [ST_W-1:0] step_cnt_q, step_cnt_d;
    logic [1:0]      pos_q, pos_d;
    logic [3:0]      led_q, led_d;
    logic [3:0]      mask;
    logic [1:0]      mode_nxt;
    logic            tick;
    logic            step;
`ifdef LED_PATTERN_PINGPONG_EN
    logic            dir_q, dir_d;
`endif

    always_comb begin
`ifdef LED_PATTERN_PINGPONG_EN
        mode_nxt = mode_q + 2'd1;
`else
        unique case (mode_q)
            MODE_ALL:   mode_nxt = MODE_CHASE;
            MODE_CHASE: mode_nxt = MODE_OFF;
            default:    mode_nxt = MODE_ALL;
        endcase
`endif
    end

    always_comb begin
        sync_d   = {sync_q[0], key_i};
        key_st_d = key_st_q;
        db_cnt_d = '0;
        if (sync_q[1] != key_st_q) begin
            if (db_cnt_q == DB_W'(DB_CYC - 1)) begin
                key_st_d = sync_q[1];
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
        // press is registered so the mode moves one edge after key_st falls
        press_d = key_st_q & ~key_st_d;
    end

    always_comb begin
        tick       = (ms_cnt_q == MS_W'(MS_CYC - 1));
        step       = tick && (step_cnt_q == ST_W'(STEP_MS - 1));
        ms_cnt_d   = tick ? '0 : ms_cnt_q + 1'b1;
        step_cnt_d = step_cnt_q;
        if (tick) begin
            step_cnt_d = step ? '0 : step_cnt_q + 1'b1;
        end
        mode_d = mode_q;
        pos_d  = pos_q;
`ifdef LED_PATTERN_PINGPONG_EN
        dir_d  = dir_q;
`endif
        if (press_q) begin
            // a mode change restarts the chase from a clean step boundary
            mode_d     = mode_nxt;
            pos_d      = '0;
            ms_cnt_d   = '0;
            step_cnt_d = '0;
`ifdef LED_PATTERN_PINGPONG_EN
            dir_d      = 1'b0;
`endif
        end else if (step) begin
            if (mode_q == MODE_CHASE) begin
                pos_d = pos_q + 2'd1;
            end
`ifdef LED_PATTERN_PINGPONG_EN
            if (mode_q == MODE_PING) begin
                if (!dir_q) begin
                    pos_d = pos_q + 2'd1;
                    if (pos_q == 2'd2) dir_d = 1'b1;
                end else begin
                    pos_d = pos_q - 2'd1;
                    if (pos_q == 2'd1) dir_d = 1'b0;
                end
            end
`endif
        end
    end

    always_comb begin
        unique case (mode_q)
            MODE_ALL:   mask = 4'b1111;
            MODE_CHASE: mask = 4'b0001 << pos_q;
            MODE_PING:  mask = 4'b0001 << pos_q;
            MODE_OFF:   mask = 4'b0000;
            default:    mask = 4'b0000;
        endcase
        led_d = mask & {4{pwm_i}};
    end

    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            sync_q     <= 2'b11;
            key_st_q   <= 1'b1;
            db_cnt_q   <= '0;
            press_q    <= 1'b0;
            mode_q     <= MODE_ALL;
            ms_cnt_q   <= '0;
            step_cnt_q <= '0;
            pos_q      <= '0;
            led_q      <= '0;
        end else begin
            sync_q     <= sync_d;
            key_st_q   <= key_st_d;
            db_cnt_q   <= db_cnt_d;
            press_q    <= press_d;
            mode_q     <= mode_d;
            ms_cnt_q   <= ms_cnt_d;
            step_cnt_q <= step_cnt_d;
            pos_q      <= pos_d;
            led_q      <= led_d;
        end
    end

`ifdef LED_PATTERN_PINGPONG_EN
    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            dir_q <= 1'b0;
        end else begin
            dir_q <= dir_d;
        end
    end
`endif

    assign led_o  = led_q;
    assign mode_o = mode_q;

endmodule
